chunk_head_arbiter: RTL
=======================

// Module: chunk_head_arbiter
// PURPOSE
//  Shares one ChunkHead (m-offset generator) between two abofs requesters (0 = B-side, 1 = A-side).
//  Arbitrates with a burst-limited round robin and latches the winner's payload into a one-entry output register.
//  Drives the ChunkHead src channel and its i_which tag. ChunkHead holds src until its id loop ends,
//  so each o_ack marks one completed chunk. Sits between the DMA-pipeline address sources and ChunkHead.
// PARAMETERS
//  MAX_BURST  1   max consecutive grants to one requester while the other is waiting (>=1)
//  CNT_BW     $clog2(MAX_BURST+1)   derived; width of the burst counter
//  WBW, VDIM, N_ICFG   TauCfg       work width, vector dims, icfg count; ICFG_BW=$clog2(N_ICFG+1)
// PORTS
//  i_clk        in   1             clock
//  i_rst        in   1             asynchronous reset, active low
//  i_r0_rdy     in   1             requester 0 valid
//  i_r0_ack     out  1             requester 0 accepted
//  i_r0_bofs    in   WBW x VDIM    requester 0 block offset
//  i_r0_aofs    in   WBW x VDIM    requester 0 alu offset
//  i_r0_beg     in   ICFG_BW       requester 0 first icfg id
//  i_r0_end     in   ICFG_BW       requester 0 end icfg id (exclusive)
//  i_r1_*       --   same as i_r0_*  requester 1
//  o_abofs_rdy  out  1             payload valid toward ChunkHead src
//  o_abofs_ack  in   1             ChunkHead src ack (chunk loop finished)
//  o_which      out  1             requester id of the held payload
//  o_bofs/o_aofs  out  WBW x VDIM  held offsets
//  o_beg/o_end  out  ICFG_BW       held icfg range
//  o_busy       out  1             =o_abofs_rdy
//  o_done_cnt   out  16            chunks completed (o_abofs_rdy&&o_abofs_ack), wraps at 2^16
// BEHAVIOUR
//  Handshake: transfer when rdy&&ack in one cycle. A rdy, once raised, holds its payload stable until ack.
//  Reset (i_rst=0, any time, async): o_abofs_rdy=0, o_which=0, o_bofs/o_aofs/o_beg/o_end=0, o_done_cnt=0,
//   last=0, burst=0. Any in-flight chunk is dropped; requesters must re-present.
//  free = !o_abofs_rdy || o_abofs_ack  (output register empty, or emptying this cycle).
//  Winner selection (combinational, evaluated only when free):
//   - only rN rdy -> N.
//   - both rdy -> last if burst<MAX_BURST, else !last.
//  i_rN_ack = free && rdy && winner==N. At most one ack per cycle. This gives 0-cycle accept and full throughput.
//  On the grant edge: o_* <= winner payload, o_which <= N, o_abofs_rdy <= 1.
//   - If N==last: burst <= sat(burst+1, MAX_BURST). Else last <= N and burst <= 1.
//  On an o_abofs_ack edge with no new grant: o_abofs_rdy <= 0. Payload regs hold their value (clock-gated, no clear).
//  o_abofs_ack && new grant in the same cycle: back-to-back load, o_abofs_rdy stays 1.
//  o_done_cnt += 1 on every o_abofs_rdy&&o_abofs_ack. It wraps 0xFFFF->0.
//  Latency: request accepted in cycle t -> o_abofs_rdy high in cycle t+1.
//  Payload is passed unmodified: no width change, no beg/end check.
//   beg==end is forwarded as is; ChunkHead's loop defines the result.
//  o_abofs_ack while o_abofs_rdy=0 is ignored: no state change, no count.
//  With MAX_BURST=1 and both requesters always rdy, grants strictly alternate.
//   No requester waits more than MAX_BURST chunks.
// TESTING
//  1 Reset, then only r0 rdy (bofs={3,5}, beg=0, end=2) -> r0_ack same cycle.
//    Next cycle o_abofs_rdy=1, o_which=0, o_bofs={3,5}.
//  2 Both rdy every cycle, MAX_BURST=1, o_abofs_ack after 3 cycles each -> o_which sequence 0,1,0,1.
//    o_done_cnt=4 after 4 acks.
//  3 MAX_BURST=2, both rdy continuously, o_abofs_ack tied high -> o_which sequence 0,0,1,1,0,0.
//    One grant per cycle, o_abofs_rdy never drops.
//  4 o_abofs_ack with r1 rdy in the same cycle -> r1_ack that cycle.
//    o_abofs_rdy stays 1, o_which=1 next cycle.
//  5 Assert i_rst=0 mid-chunk (o_abofs_rdy=1, o_done_cnt=7) -> all outputs 0 immediately (async).
//    After release, the first tie goes to r0.
//  6 o_abofs_ack pulsed with o_abofs_rdy=0, and o_done_cnt preset to 0xFFFF then one transfer ->
//    no state change for the stray ack; counter wraps to 0.

Source files
------------

// File: rtl/chunk_head_arbiter.sv
// Burst-limited round-robin arbiter sharing one ChunkHead src channel between two abofs requesters.
// The winner's payload is latched into a one-entry output register that ChunkHead holds until its loop ends.
module chunk_head_arbiter #(
  parameter int unsigned MAX_BURST = 1,
  parameter int unsigned WBW       = 8,
  parameter int unsigned VDIM      = 2,
  parameter int unsigned N_ICFG    = 4,
  localparam int unsigned CNT_BW   = $clog2(MAX_BURST + 1),
  localparam int unsigned ICFG_BW  = $clog2(N_ICFG + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_r0_rdy,
  output logic                          i_r0_ack,
  input  logic [VDIM-1:0][WBW-1:0]      i_r0_bofs,
  input  logic [VDIM-1:0][WBW-1:0]      i_r0_aofs,
  input  logic [ICFG_BW-1:0]            i_r0_beg,
  input  logic [ICFG_BW-1:0]            i_r0_end,
  input  logic                          i_r1_rdy,
  output logic                          i_r1_ack,
  input  logic [VDIM-1:0][WBW-1:0]      i_r1_bofs,
  input  logic [VDIM-1:0][WBW-1:0]      i_r1_aofs,
  input  logic [ICFG_BW-1:0]            i_r1_beg,
  input  logic [ICFG_BW-1:0]            i_r1_end,
  output logic                          o_abofs_rdy,
  input  logic                          o_abofs_ack,
  output logic                          o_which,
  output logic [VDIM-1:0][WBW-1:0]      o_bofs,
  output logic [VDIM-1:0][WBW-1:0]      o_aofs,
  output logic [ICFG_BW-1:0]            o_beg,
  output logic [ICFG_BW-1:0]            o_end,
  output logic                          o_busy,
  output logic [15:0]                   o_done_cnt
);

  localparam logic [CNT_BW-1:0] BURST_MAX = CNT_BW'(MAX_BURST);

  logic              last;
  logic [CNT_BW-1:0] burst;
  logic              free_c;
  logic              grant_c;
  logic              win_c;

  // Output register is empty or draining this cycle, so a new request may be taken.
  assign free_c = !o_abofs_rdy || o_abofs_ack;

  // Winner selection: sole requester wins; on a tie stay on `last` until its burst is used up.
  always_comb begin
    grant_c = 1'b0;
    win_c   = 1'b0;
    if (free_c) begin
      if (i_r0_rdy && i_r1_rdy) begin
        grant_c = 1'b1;
        win_c   = (burst < BURST_MAX) ? last : !last;
      end else if (i_r0_rdy) begin
        grant_c = 1'b1;
        win_c   = 1'b0;
      end else if (i_r1_rdy) begin
        grant_c = 1'b1;
        win_c   = 1'b1;
      end
    end
  end

  assign i_r0_ack = grant_c && !win_c;
  assign i_r1_ack = grant_c &&  win_c;
  assign o_busy   = o_abofs_rdy;

  // Control: valid flag, fairness history and completed-chunk counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_abofs_rdy <= 1'b0;
      o_which     <= 1'b0;
      last        <= 1'b0;
      burst       <= '0;
      o_done_cnt  <= '0;
    end else begin
      if (o_abofs_rdy && o_abofs_ack) begin
        o_done_cnt <= o_done_cnt + 16'd1;
      end
      if (grant_c) begin
        o_abofs_rdy <= 1'b1;
        o_which     <= win_c;
        if (win_c == last) begin
          burst <= (burst == BURST_MAX) ? burst : burst + CNT_BW'(1);
        end else begin
          last  <= win_c;
          burst <= CNT_BW'(1);
        end
      end else if (o_abofs_ack) begin
        o_abofs_rdy <= 1'b0;
      end
    end
  end

  // Payload register: loads only on a grant, otherwise holds.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_bofs <= '0;
      o_aofs <= '0;
      o_beg  <= '0;
      o_end  <= '0;
    end else if (grant_c) begin
      o_bofs <= win_c ? i_r1_bofs : i_r0_bofs;
      o_aofs <= win_c ? i_r1_aofs : i_r0_aofs;
      o_beg  <= win_c ? i_r1_beg  : i_r0_beg;
      o_end  <= win_c ? i_r1_end  : i_r0_end;
    end
  end

endmodule
